// File: rtl/rst_sequencer.sv
// Staged reset sequencer: waits for a stable clock lock, releases core, display, then mouse resets.
// Optional lock-loss event counter on loss_cnt when RST_SEQ_LOSS_CNT_EN is defined.
module rst_sequencer #(
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int GLITCH_CYCLES = 4
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       locked_in,
  input  logic       soft_rst_req,
  output logic       reset_core,
  output logic       reset_display,
  output logic       reset_mouse,
  output logic       ready,
  output logic [7:0] loss_cnt
);

  localparam int MAX_AB = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int MAX_C  = (MAX_AB > GLITCH_CYCLES) ? MAX_AB : GLITCH_CYCLES;
  localparam int CW     = $clog2(MAX_C);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] GLITCH_LAST = CW'(GLITCH_CYCLES - 1);

  localparam logic [2:0] S_HOLD     = 3'd0;
  localparam logic [2:0] S_REL_CORE = 3'd1;
  localparam logic [2:0] S_REL_DISP = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_SOFT     = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_gcnt;
  logic          r_reset_core;
  logic          r_reset_display;
  logic          r_reset_mouse;
  logic          r_ready;

  logic [2:0]    w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [CW-1:0] w_nxt_gcnt;
  logic          w_loss;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_loss      = 1'b0;
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_gcnt  = '0;
    // Low-run counter persists across non-HOLD state changes; any high sample clears it.
    if ((r_state != S_HOLD) && !r_sync2) begin
      if (r_gcnt == GLITCH_LAST) w_loss = 1'b1;
      else                       w_nxt_gcnt = r_gcnt + 1'b1;
    end
    case (r_state)
      S_HOLD: begin
        if (r_sync2) begin
          if (r_cnt == STABLE_LAST) begin
            w_nxt_state = S_REL_CORE;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = r_cnt + 1'b1;
          end
        end else begin
          w_nxt_cnt = '0;
        end
      end
      S_REL_CORE, S_REL_DISP, S_SOFT: begin
        if (r_cnt == STAGE_LAST) begin
          w_nxt_cnt = '0;
          case (r_state)
            S_REL_CORE: w_nxt_state = S_REL_DISP;
            S_REL_DISP: w_nxt_state = S_RUN;
            default:    w_nxt_state = S_REL_CORE;
          endcase
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_RUN: begin
        w_nxt_cnt = '0;
        if (soft_rst_req) w_nxt_state = S_SOFT;
      end
      default: begin
        w_nxt_state = S_HOLD;
        w_nxt_cnt   = '0;
      end
    endcase
    // Lock loss outranks every other transition, including a soft request.
    if (w_loss) begin
      w_nxt_state = S_HOLD;
      w_nxt_cnt   = '0;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_HOLD;
      r_cnt           <= '0;
      r_gcnt          <= '0;
      r_reset_core    <= 1'b1;
      r_reset_display <= 1'b1;
      r_reset_mouse   <= 1'b1;
      r_ready         <= 1'b0;
    end else begin
      r_state         <= w_nxt_state;
      r_cnt           <= w_nxt_cnt;
      r_gcnt          <= w_nxt_gcnt;
      r_reset_core    <= (w_nxt_state == S_HOLD) || (w_nxt_state == S_SOFT);
      r_reset_display <= (w_nxt_state != S_REL_DISP) && (w_nxt_state != S_RUN);
      r_reset_mouse   <= (w_nxt_state != S_RUN);
      r_ready         <= (w_nxt_state == S_RUN);
    end
  end

  assign reset_core    = r_reset_core;
  assign reset_display = r_reset_display;
  assign reset_mouse   = r_reset_mouse;
  assign ready         = r_ready;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [7:0] r_loss_cnt;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)                            r_loss_cnt <= 8'd0;
    else if (w_loss && (r_loss_cnt != 8'hFF)) r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  assign loss_cnt = r_loss_cnt;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer with STABLE_CYCLES=8, STAGE_GAP=4, GLITCH_CYCLES=3.
module tb_rst_sequencer;

  logic       pclk;
  logic       rst;
  logic       locked_in;
  logic       soft_rst_req;
  logic       reset_core;
  logic       reset_display;
  logic       reset_mouse;
  logic       ready;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [11:0] exp;
    string       tag;
  } ev_t;

  ev_t sb[$];

  rst_sequencer #(
    .STABLE_CYCLES(8),
    .STAGE_GAP(4),
    .GLITCH_CYCLES(3)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .locked_in(locked_in),
    .soft_rst_req(soft_rst_req),
    .reset_core(reset_core),
    .reset_display(reset_display),
    .reset_mouse(reset_mouse),
    .ready(ready),
    .loss_cnt(loss_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [11:0] obs_vec();
    return {reset_core, reset_display, reset_mouse, ready, loss_cnt};
  endfunction

  // Expected loss count after n lock-loss events.
  function automatic logic [7:0] exp_lc(input int n);
`ifdef RST_SEQ_LOSS_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic push(input int c, input logic [3:0] o, input logic [7:0] l, input string tag);
    ev_t e;
    e.cyc = c;
    e.exp = {o, l};
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge pclk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      ev_t e;
      e = sb.pop_front();
      if (e.cyc < cyc) chk({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
      else             chk(e.tag, 32'(obs_vec()), 32'(e.exp));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wait_sb(input int budget);
    int left;
    left = budget;
    while (sb.size() > 0 && left > 0) begin
      @(posedge pclk);
      left = left - 1;
    end
    #1;
    if (sb.size() > 0) begin
      chk("sb_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic pulse_rst();
    locked_in = 1'b0;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] l1;
    logic [7:0] l2;
    l1 = exp_lc(1);
    l2 = exp_lc(2);
    rst = 1'b0;
    locked_in = 1'b0;
    soft_rst_req = 1'b0;

    #12;
    chk("reset_vals", 32'(obs_vec()), 32'({4'b1110, 8'd0}));
    step(1);
    rst = 1'b1;
    step(3);

    // Two-cycle dip during the stability count restarts it.
    base = cyc;
    locked_in = 1'b1;
    push(base + 16, 4'b1110, 8'd0, "t28_hold");
    push(base + 17, 4'b0110, 8'd0, "t28_core");
    push(base + 21, 4'b0010, 8'd0, "t28_disp");
    push(base + 25, 4'b0001, 8'd0, "t28_run");
    step(5);
    locked_in = 1'b0;
    step(2);
    locked_in = 1'b1;
    wait_sb(40);

    // Short low run in RUN is ignored.
    step(2);
    base = cyc;
    locked_in = 1'b0;
    push(base + 4, 4'b0001, 8'd0, "t29_short_a");
    push(base + 8, 4'b0001, 8'd0, "t29_short_b");
    step(2);
    locked_in = 1'b1;
    wait_sb(20);

    // Three-cycle low run is a lock loss; relock re-sequences.
    step(2);
    base = cyc;
    locked_in = 1'b0;
    push(base + 4,  4'b0001, 8'd0, "t29_pre");
    push(base + 5,  4'b1110, l1,   "t29_loss");
    push(base + 12, 4'b1110, l1,   "t29_hold");
    push(base + 13, 4'b0110, l1,   "t29_core");
    push(base + 17, 4'b0010, l1,   "t29_disp");
    push(base + 21, 4'b0001, l1,   "t29_run");
    step(3);
    locked_in = 1'b1;
    wait_sb(40);

    // Soft reset from RUN; a second request in REL_CORE is ignored.
    step(2);
    base = cyc;
    soft_rst_req = 1'b1;
    push(base,      4'b0001, l1, "t30_pre");
    push(base + 1,  4'b1110, l1, "t30_soft");
    push(base + 4,  4'b1110, l1, "t30_soft_end");
    push(base + 5,  4'b0110, l1, "t30_core");
    push(base + 8,  4'b0110, l1, "t30_ignored");
    push(base + 9,  4'b0010, l1, "t30_disp");
    push(base + 13, 4'b0001, l1, "t30_run");
    step(1);
    soft_rst_req = 1'b0;
    step(5);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    wait_sb(30);

    // Lock loss and soft request in the same cycle: HOLD wins.
    step(2);
    base = cyc;
    locked_in = 1'b0;
    push(base + 4,  4'b0001, l1, "t20_pre");
    push(base + 5,  4'b1110, l2, "t20_loss");
    push(base + 9,  4'b1110, l2, "t20_no_soft");
    push(base + 15, 4'b1110, l2, "t20_hold");
    push(base + 16, 4'b0110, l2, "t20_core");
    push(base + 24, 4'b0001, l2, "t20_run");
    step(4);
    soft_rst_req = 1'b1;
    step(1);
    soft_rst_req = 1'b0;
    step(1);
    locked_in = 1'b1;
    wait_sb(40);

    // Nominal release timing from a fresh reset.
    pulse_rst();
    base = cyc;
    locked_in = 1'b1;
    push(base + 9,  4'b1110, 8'd0, "t27_hold");
    push(base + 10, 4'b0110, 8'd0, "t27_core");
    push(base + 13, 4'b0110, 8'd0, "t27_core_end");
    push(base + 14, 4'b0010, 8'd0, "t27_disp");
    push(base + 17, 4'b0010, 8'd0, "t27_disp_end");
    push(base + 18, 4'b0001, 8'd0, "t27_run");
    wait_sb(30);

    // Asynchronous reset while in REL_DISP.
    pulse_rst();
    locked_in = 1'b1;
    step(15);
    chk("t31_pre", 32'(obs_vec()), 32'({4'b0010, 8'd0}));
    #2;
    rst = 1'b0;
    #1;
    chk("t31_async", 32'(obs_vec()), 32'({4'b1110, 8'd0}));
    locked_in = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);

    // 256 lock-loss events: counter saturates.
    for (int k = 0; k < 256; k++) begin
      base = cyc;
      locked_in = 1'b1;
      push(base + 10, 4'b0110, exp_lc(k),     "t32_rel");
      push(base + 15, 4'b1110, exp_lc(k + 1), "t32_loss");
      step(10);
      locked_in = 1'b0;
      step(3);
    end
    wait_sb(50);
    chk("t32_final", 32'(loss_cnt), 32'(exp_lc(256)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
